stos_com_align: RTL
===================

// Module: stos_com_align
// PURPOSE
//  Receive end of the parallel-to-serial IDLE/COM link. Samples the serial line once per clk32f,
//  finds the byte boundary by hunting for the COM symbol (8'hBC), and requires COM_COUNT
//  consecutive aligned COMs before declaring the link active. While active, it emits each
//  received byte as an 8-bit word. COM bytes are the transmitter's idle filler and are not
//  delivered as data.
// PARAMETERS
//  COM        8'hBC  comma/idle symbol used for alignment and idle fill
//  COM_COUNT  4      consecutive aligned COMs needed to go ACTIVE (legal range 1..15)
// PORTS
//  clk32f     in   1  bit-rate clock; single clock domain
//  reset      in   1  synchronous, active-high reset
//  serial_in  in   1  serial data, MSB first, one bit per clk32f rising edge
//  data_out   out  8  last delivered data byte
//  valid_out  out  1  one-cycle pulse; data_out holds a new non-COM byte
//  active     out  1  high while the link is aligned and locked (state ACTIVE)
// BEHAVIOUR
//  Reset (synchronous, active-high, on the rising edge of clk32f):
//   - state=SEARCH; shift, bit_cnt and com_cnt = 0.
//   - data_out=8'h00, valid_out=0, active=0.
//   - Reset overrides all other activity, including mid-byte and in ACTIVE.
//   - Bits sampled while reset is high are discarded.
//  Datapath: nxt = {shift[6:0], serial_in}; shift <= nxt on every edge when not in reset.
//   - bit_cnt is a 3-bit counter that wraps 7->0.
//   - A byte completes on the edge where bit_cnt==7; the completed byte is nxt.
//  FSM (encoded state, registered):
//   SEARCH: bit-by-bit hunt. If nxt==COM, then bit_cnt<=0 and com_cnt<=1.
//     - If COM_COUNT==1, go to ACTIVE; otherwise go to SYNC.
//     - If nxt!=COM, remain in SEARCH. bit_cnt is frozen at 0.
//   SYNC: bit_cnt advances every edge. At byte completion:
//     - nxt==COM: com_cnt<=com_cnt+1; when com_cnt+1==COM_COUNT, go to ACTIVE.
//     - nxt!=COM: go to SEARCH, com_cnt<=0 (false lock). No realignment within this same edge.
//   ACTIVE: bit_cnt advances every edge. At byte completion:
//     - nxt!=COM: data_out<=nxt, valid_out<=1 for exactly one cycle.
//     - nxt==COM: idle; valid_out stays 0 and data_out holds its previous value.
//     - ACTIVE is left only by reset; the block never realigns in ACTIVE.
//  active is registered: it rises on the edge that completes the COM_COUNT-th COM.
//  Latency: the last bit of a byte is sampled at edge N; data_out and valid_out are visible
//   after edge N, i.e. a 1-edge latency from that last bit.
//  valid_out is 0 on every edge that is not an ACTIVE byte completion, so pulses are at least
//   8 cycles apart. There is no backpressure; the consumer must take data on valid_out.
//  com_cnt is 4 bits wide and saturates, so it never wraps.
// TESTING
//  1 reset=1 for 8 edges, serial_in toggling -> data_out=00, valid_out=0, active=0 throughout.
//  2 3 junk bits (101), then 4x BC -> active rises on the edge after bit 32 of the COMs; valid_out never pulses.
//  3 in ACTIVE send EE,BC,BC,12 -> valid_out pulses twice, 24 edges apart; data_out=EE then 12;
//    data_out stays EE during the COMs.
//  4 reset, then BC,BC,55,BC,BC,BC,BC -> active stays 0 through 55 (back to SEARCH);
//    active rises after the 4th trailing BC.
//  5 in ACTIVE mid-byte, assert reset 1 edge -> all outputs 0 on the next edge;
//    4x BC are needed again to reassert active.
//  6 COM_COUNT=1 build: single BC after junk -> active after that BC; the next byte A5 gives valid_out with data_out=A5.

Source files
------------

// File: rtl/stos_com_align.sv
// Receive side of the serial IDLE/COM link: hunts for the COM byte boundary, locks after
// COM_COUNT aligned COMs, then delivers every non-COM byte with a one-cycle valid pulse.
module stos_com_align #(
  parameter logic [7:0] COM       = 8'hBC,
  parameter int         COM_COUNT = 4
) (
  input  logic       clk32f,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

  state_t     r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_com_cnt;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_active;

  logic [7:0] w_nxt;
  logic       w_is_com;
  logic       w_byte_done;
  logic [3:0] w_com_inc;

  assign w_nxt       = {r_shift[6:0], serial_in};
  assign w_is_com    = (w_nxt == COM);
  assign w_byte_done = (r_bit_cnt == 3'd7);
  // Saturating increment keeps the COM counter from wrapping back below the target.
  assign w_com_inc   = (r_com_cnt == 4'hF) ? 4'hF : r_com_cnt + 4'd1;

  always_ff @(posedge clk32f) begin
    if (reset) begin
      r_state   <= SEARCH;
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_com_cnt <= 4'd0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_shift <= w_nxt;
      r_valid <= 1'b0;
      case (r_state)
        SEARCH: begin
          // Bit-by-bit hunt: the boundary is fixed by the first window that equals COM.
          r_bit_cnt <= 3'd0;
          if (w_is_com) begin
            r_com_cnt <= 4'd1;
            if (COM_TARGET == 4'd1) begin
              r_state  <= ACTIVE;
              r_active <= 1'b1;
            end else begin
              r_state <= SYNC;
            end
          end
        end
        SYNC: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_byte_done) begin
            if (w_is_com) begin
              r_com_cnt <= w_com_inc;
              if (w_com_inc == COM_TARGET) begin
                r_state  <= ACTIVE;
                r_active <= 1'b1;
              end
            end else begin
              // False lock; the hunt restarts on the following bit.
              r_state   <= SEARCH;
              r_com_cnt <= 4'd0;
            end
          end
        end
        ACTIVE: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_byte_done && !w_is_com) begin
            r_data  <= w_nxt;
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state   <= SEARCH;
          r_bit_cnt <= 3'd0;
          r_com_cnt <= 4'd0;
          r_active  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign active    = r_active;

endmodule
